// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe board keeper: cell codes, winner codes,
// sequencer states and the table of the eight winning lines.
package ttt_pkg;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] PLAYER = 2'b01;
    localparam logic [1:0] CPU    = 2'b10;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_CPU    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAYER,
        ST_EVAL,
        ST_CPU_WAIT,
        ST_CPU_MOVE,
        ST_OVER
    } state_t;

    // Zero-based cell indices (cell n of the board is index n-1).
    localparam int LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

endpackage

// File: rtl/line_judge.sv
// Combinational board judge: win detection for both sides, full-board flag
// and the lowest-numbered empty cell (1..9, 0 when the board is full).
module line_judge
    import ttt_pkg::*;
(
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic       player_win,
    output logic       cpu_win,
    output logic       board_full,
    output logic [3:0] first_empty
);

    logic [1:0] cells [9];

    assign cells = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};

    // Scan all lines for a triple, and scan cells high-to-low so the lowest empty wins.
    always_comb begin
        player_win  = 1'b0;
        cpu_win     = 1'b0;
        board_full  = 1'b1;
        first_empty = 4'd0;
        for (int l = 0; l < 8; l++) begin
            if (cells[LINES[l][0]] == PLAYER && cells[LINES[l][1]] == PLAYER &&
                cells[LINES[l][2]] == PLAYER)
                player_win = 1'b1;
            if (cells[LINES[l][0]] == CPU && cells[LINES[l][1]] == CPU &&
                cells[LINES[l][2]] == CPU)
                cpu_win = 1'b1;
        end
        for (int i = 8; i >= 0; i--) begin
            if (cells[i] == EMPTY) begin
                board_full  = 1'b0;
                first_empty = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/board_keeper.sv
// Authoritative tic-tac-toe board and turn sequencer. Takes player moves over
// valid/ready, applies the suggestion engine's move (or the lowest empty cell),
// and judges wins and draws after every move.
module board_keeper
    import ttt_pkg::*;
#(
    parameter int CPU_WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       player_valid,
    input  logic [3:0] player_pos,
    output logic       player_ready,
    input  logic       cpu_check,
    input  logic [3:0] cpu_pos,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [3:0] move_count
);

    localparam int CW = $clog2(CPU_WAIT_CYCLES + 1);

    state_t        state, state_next;
    logic [1:0]    cells [9];
    logic          last_cpu;
    logic [CW-1:0] wait_cnt;

    logic          do_clear, wr_en, load_cnt, set_winner, bad_move;
    logic [3:0]    wr_idx;
    logic [1:0]    wr_val, winner_next;
    logic          player_legal, cpu_ok;
    logic          player_win, cpu_win, board_full;
    logic [3:0]    first_empty;

    line_judge u_judge (
        .pos1(cells[0]), .pos2(cells[1]), .pos3(cells[2]),
        .pos4(cells[3]), .pos5(cells[4]), .pos6(cells[5]),
        .pos7(cells[6]), .pos8(cells[7]), .pos9(cells[8]),
        .player_win(player_win), .cpu_win(cpu_win),
        .board_full(board_full), .first_empty(first_empty)
    );

    assign pos1 = cells[0];
    assign pos2 = cells[1];
    assign pos3 = cells[2];
    assign pos4 = cells[3];
    assign pos5 = cells[4];
    assign pos6 = cells[5];
    assign pos7 = cells[6];
    assign pos8 = cells[7];
    assign pos9 = cells[8];

    assign player_ready = (state == ST_PLAYER);
    assign game_over    = (state == ST_OVER);

    // Range is checked first so the cell lookup only matters for cells 1..9.
    assign player_legal = (player_pos >= 4'd1) && (player_pos <= 4'd9) &&
                          (cells[player_pos - 4'd1] == EMPTY);
    assign cpu_ok       = cpu_check && (cpu_pos >= 4'd1) && (cpu_pos <= 4'd9) &&
                          (cells[cpu_pos - 4'd1] == EMPTY);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and board-update decisions; start overrides every state.
    always_comb begin
        state_next  = state;
        do_clear    = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = 4'd0;
        wr_val      = EMPTY;
        load_cnt    = 1'b0;
        set_winner  = 1'b0;
        winner_next = WIN_NONE;
        bad_move    = 1'b0;
        if (start) begin
            do_clear   = 1'b1;
            state_next = ST_PLAYER;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_PLAYER: begin
                    if (player_valid) begin
                        if (player_legal) begin
                            wr_en      = 1'b1;
                            wr_idx     = player_pos - 4'd1;
                            wr_val     = PLAYER;
                            state_next = ST_EVAL;
                        end else begin
                            bad_move = 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    // board_full is equivalent to move_count == 9: every write fills one empty cell.
                    if (player_win) begin
                        set_winner  = 1'b1;
                        winner_next = WIN_PLAYER;
                        state_next  = ST_OVER;
                    end else if (cpu_win) begin
                        set_winner  = 1'b1;
                        winner_next = WIN_CPU;
                        state_next  = ST_OVER;
                    end else if (board_full) begin
                        set_winner  = 1'b1;
                        winner_next = WIN_NONE;
                        state_next  = ST_OVER;
                    end else if (!last_cpu) begin
                        load_cnt   = 1'b1;
                        state_next = ST_CPU_WAIT;
                    end else begin
                        state_next = ST_PLAYER;
                    end
                end
                ST_CPU_WAIT: begin
                    if (wait_cnt == '0) state_next = ST_CPU_MOVE;
                end
                ST_CPU_MOVE: begin
                    // EVAL never lets a full board reach here, so first_empty is always 1..9.
                    wr_en      = 1'b1;
                    wr_idx     = cpu_ok ? (cpu_pos - 4'd1) : (first_empty - 4'd1);
                    wr_val     = CPU;
                    state_next = ST_EVAL;
                end
                ST_OVER: ;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Board, counters, winner and the registered illegal pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) cells[i] <= EMPTY;
            move_count <= 4'd0;
            winner     <= WIN_NONE;
            illegal    <= 1'b0;
            last_cpu   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            illegal <= bad_move;
            if (do_clear) begin
                for (int i = 0; i < 9; i++) cells[i] <= EMPTY;
                move_count <= 4'd0;
                winner     <= WIN_NONE;
                last_cpu   <= 1'b0;
            end else begin
                if (wr_en) begin
                    cells[wr_idx] <= wr_val;
                    move_count    <= move_count + 4'd1;
                    last_cpu      <= (wr_val == CPU);
                end
                if (set_winner) winner <= winner_next;
            end
            if (load_cnt)
                wait_cnt <= CW'(CPU_WAIT_CYCLES - 1);
            else if (state == ST_CPU_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_board_keeper.sv
// Self-checking bench for board_keeper: a table of whole-move vectors with
// hand-computed boards, plus hand-written latency, freeze and reset sequences.
module tb_board_keeper;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset, start, player_valid, cpu_check;
    logic [3:0] player_pos, cpu_pos;
    logic       player_ready, illegal, game_over;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, winner;
    logic [3:0] move_count;
    logic [17:0] board_now;

    int checks = 0;
    int failures = 0;

    board_keeper #(.CPU_WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .player_valid(player_valid), .player_pos(player_pos), .player_ready(player_ready),
        .cpu_check(cpu_check), .cpu_pos(cpu_pos),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .illegal(illegal), .game_over(game_over), .winner(winner), .move_count(move_count)
    );

    always #5 clk = ~clk;

    assign board_now = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    typedef struct {
        bit          do_start;
        logic [3:0]  pos;
        bit          cc;
        logic [3:0]  cp;
        logic [17:0] eb;
        logic [3:0]  emc;
        bit          eill;
        bit          ego;
        logic [1:0]  ew;
        bit          erdy;
    } vec_t;

    vec_t vt[$];

    // 'X' = player (01), 'O' = cpu (10), anything else empty; character i is cell i+1.
    function automatic logic [17:0] mkb(input string s);
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) begin
            if (s[i] == "X")      b[2*i +: 2] = 2'b01;
            else if (s[i] == "O") b[2*i +: 2] = 2'b10;
        end
        return b;
    endfunction

    function automatic vec_t mv(input bit st, input logic [3:0] pos, input bit cc,
                                input logic [3:0] cp, input string b, input int mc,
                                input bit ill, input bit go, input logic [1:0] w,
                                input bit rdy);
        vec_t v;
        v.do_start = st; v.pos = pos; v.cc = cc; v.cp = cp; v.eb = mkb(b);
        v.emc = 4'(mc); v.eill = ill; v.ego = go; v.ew = w; v.erdy = rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!player_ready && n < 40) begin
            step();
            n++;
        end
        if (!player_ready) chk({nm, "_ready_timeout"}, 32'(player_ready), 32'd1);
    endtask

    task automatic chk_all(input string nm, input logic [17:0] b, input int mc,
                           input bit ill, input bit go, input logic [1:0] w, input bit rdy);
        chk({nm, "_board"}, 32'(board_now), 32'(b));
        chk({nm, "_count"}, 32'(move_count), 32'(mc));
        chk({nm, "_illegal"}, 32'(illegal), 32'(ill));
        chk({nm, "_over"}, 32'(game_over), 32'(go));
        chk({nm, "_winner"}, 32'(winner), 32'(w));
        chk({nm, "_ready"}, 32'(player_ready), 32'(rdy));
    endtask

    task automatic apply(input int idx, input vec_t v);
        string nm = $sformatf("vec%0d", idx);
        int n;
        if (v.do_start) begin
            pulse_start();
            chk_all(nm, v.eb, v.emc, 1'b0, v.ego, v.ew, v.erdy);
        end else begin
            wait_ready(nm);
            player_valid = 1'b1; player_pos = v.pos; cpu_check = v.cc; cpu_pos = v.cp;
            step();
            player_valid = 1'b0;
            chk({nm, "_illegal_pulse"}, 32'(illegal), 32'(v.eill));
            if (v.eill) begin
                step();
                chk({nm, "_illegal_width"}, 32'(illegal), 32'd0);
            end else begin
                n = 0;
                while (!(player_ready || game_over) && n < 40) begin
                    step();
                    n++;
                end
                if (n >= 40) chk({nm, "_settle_timeout"}, 32'd0, 32'd1);
            end
            chk_all(nm, v.eb, v.emc, 1'b0, v.ego, v.ew, v.erdy);
        end
    endtask

    task automatic accept_move(input logic [3:0] p, input bit cc, input logic [3:0] cp);
        wait_ready("accept");
        player_valid = 1'b1; player_pos = p; cpu_check = cc; cpu_pos = cp;
        step();
        player_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; player_valid = 1'b0; player_pos = 4'd0;
        cpu_check = 1'b0; cpu_pos = 4'd0;
        repeat (3) step();
        chk_all("reset", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(player_ready), 32'd0);

        // Exact latency of the first exchange.
        pulse_start();
        chk("start_ready", 32'(player_ready), 32'd1);
        accept_move(4'd5, 1'b1, 4'd1);
        chk("lat_pos5", 32'(pos5), 32'd1);
        chk("lat_ready_low", 32'(player_ready), 32'd0);
        repeat (1 + W) step();
        chk("lat_pos1_before", 32'(pos1), 32'd0);
        step();
        chk("lat_pos1_cpu", 32'(pos1), 32'd2);
        chk("lat_ready_still_low", 32'(player_ready), 32'd0);
        step();
        chk("lat_ready_back", 32'(player_ready), 32'd1);
        chk("lat_count", 32'(move_count), 32'd2);

        // Game A: illegal requests, fallback moves, player diagonal win.
        vt.push_back(mv(1, 0, 0, 0, ".........", 0, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 5, 1, 1, "O...X....", 2, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 5, 1, 1, "O...X....", 2, 1, 0, 2'b00, 1));
        vt.push_back(mv(0, 0, 1, 1, "O...X....", 2, 1, 0, 2'b00, 1));
        vt.push_back(mv(0, 10, 1, 1, "O...X....", 2, 1, 0, 2'b00, 1));
        vt.push_back(mv(0, 9, 0, 1, "OO..X...X", 4, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 3, 1, 5, "OOXOX...X", 6, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 7, 1, 6, "OOXOX.X.X", 7, 0, 1, 2'b01, 0));
        // Game B: player row 1,2,3 with CPU forced to 7,8.
        vt.push_back(mv(1, 0, 0, 0, ".........", 0, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 1, 1, 7, "X.....O..", 2, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 2, 1, 8, "XX....OO.", 4, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 3, 1, 9, "XXX...OO.", 5, 0, 1, 2'b01, 0));
        // Game D: draw X O X / X O O / O X X.
        vt.push_back(mv(1, 0, 0, 0, ".........", 0, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 1, 1, 2, "XO.......", 2, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 3, 1, 5, "XOX.O....", 4, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 4, 1, 7, "XOXXO.O..", 6, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 8, 1, 6, "XOXXOOOX.", 8, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 9, 1, 1, "XOXXOOOXX", 9, 0, 1, 2'b00, 0));
        // Game C: CPU completes 4,5,6.
        vt.push_back(mv(1, 0, 0, 0, ".........", 0, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 1, 1, 4, "X..O.....", 2, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 2, 1, 5, "XX.OO....", 4, 0, 0, 2'b00, 1));
        vt.push_back(mv(0, 9, 1, 6, "XX.OOO..X", 6, 0, 1, 2'b10, 0));

        foreach (vt[i]) apply(i, vt[i]);

        // OVER ignores moves and keeps board and winner frozen.
        player_valid = 1'b1; player_pos = 4'd7;
        repeat (2) step();
        player_valid = 1'b0;
        chk_all("frozen", mkb("XX.OOO..X"), 6, 1'b0, 1'b1, 2'b10, 1'b0);
        pulse_start();
        chk_all("restart", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b1);

        // Asynchronous reset during CPU_WAIT.
        accept_move(4'd5, 1'b1, 4'd1);
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        chk_all("rst_wait", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        reset = 1'b0;
        repeat (W + 4) step();
        chk_all("rst_idle", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b0);
        pulse_start();
        chk_all("rst_start", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b1);

        // start during CPU_WAIT discards the pending CPU move.
        accept_move(4'd5, 1'b1, 4'd1);
        step();
        pulse_start();
        chk_all("mid_start", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b1);
        repeat (W + 3) step();
        chk_all("mid_start_late", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b1);

        // start and a move in the same cycle: the move is ignored.
        start = 1'b1; player_valid = 1'b1; player_pos = 4'd3;
        step();
        start = 1'b0; player_valid = 1'b0;
        chk_all("start_vs_move", 18'd0, 0, 1'b0, 1'b0, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
